// File: rtl/instr_fetch_queue.sv
// rtl/instr_fetch_queue.sv - in-order instruction fetch queue between PC and decode
module instr_fetch_queue #(
  parameter int AW           = 36,
  parameter int IW           = 36,
  parameter int DEPTH        = 4,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [AW-1:0] i_pc,
  output logic          o_pc_advance,
  output logic          o_imem_req_valid,
  output logic [AW-1:0] o_imem_addr,
  input  logic          i_imem_req_ready,
  input  logic          i_imem_rsp_valid,
  input  logic [IW-1:0] i_imem_rsp_data,
  input  logic          i_redirect,
  output logic          o_inst_valid,
  output logic [IW-1:0] o_inst,
  output logic [AW-1:0] o_inst_pc,
  input  logic          i_inst_ready,
  output logic          o_err_spurious
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int FW = $clog2(MAX_INFLIGHT + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [FW-1:0] MAXF_C  = FW'(MAX_INFLIGHT);

  logic [AW-1:0]    ent_pc     [DEPTH];
  logic [IW-1:0]    ent_inst   [DEPTH];
  logic [DEPTH-1:0] ent_filled;

  logic [PW-1:0] alloc_ptr, fill_ptr, rd_ptr;
  logic [CW-1:0] alloc_cnt;
  logic [FW-1:0] inflight, drop_cnt, inflight_nxt;
  logic          err_q;

  logic accept, pop, rsp_live, rsp_drop, rsp_fill, rsp_spurious;

  // Outputs are held low while reset is asserted so the request port is quiet during reset.
  assign o_imem_req_valid = i_rst_n & !i_redirect & (alloc_cnt < DEPTH_C) & (inflight < MAXF_C);
  assign o_imem_addr      = i_pc;
  assign accept           = o_imem_req_valid & i_imem_req_ready;
  assign o_pc_advance     = accept;

  assign o_inst_valid = !i_redirect & (alloc_cnt != '0) & ent_filled[rd_ptr];
  assign o_inst       = ent_inst[rd_ptr];
  assign o_inst_pc    = ent_pc[rd_ptr];
  assign pop          = o_inst_valid & i_inst_ready;

  // A response only counts against inflight when something is actually outstanding.
  assign rsp_live     = i_imem_rsp_valid & (inflight != '0);
  assign rsp_drop     = rsp_live & ((drop_cnt != '0) | i_redirect);
  assign rsp_fill     = rsp_live & (drop_cnt == '0) & !i_redirect;
  assign rsp_spurious = i_imem_rsp_valid & (inflight == '0) & !accept;

  assign o_err_spurious = err_q;

  // Next outstanding-request count; also seeds drop_cnt on a redirect.
  always_comb begin
    inflight_nxt = inflight + FW'(accept) - FW'(rsp_live);
  end

  // Pointers, counters and the sticky spurious-response flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      rd_ptr    <= '0;
      alloc_cnt <= '0;
      inflight  <= '0;
      drop_cnt  <= '0;
      err_q     <= 1'b0;
    end else begin
      inflight <= inflight_nxt;
      if (rsp_spurious) err_q <= 1'b1;
      if (i_redirect) begin
        alloc_cnt <= '0;
        alloc_ptr <= rd_ptr;
        fill_ptr  <= rd_ptr;
        drop_cnt  <= inflight_nxt;
      end else begin
        if (accept)   alloc_ptr <= alloc_ptr + PW'(1);
        if (rsp_fill) fill_ptr  <= fill_ptr + PW'(1);
        if (pop)      rd_ptr    <= rd_ptr + PW'(1);
        if (rsp_drop) drop_cnt  <= drop_cnt - FW'(1);
        case ({accept, pop})
          2'b10:   alloc_cnt <= alloc_cnt + CW'(1);
          2'b01:   alloc_cnt <= alloc_cnt - CW'(1);
          default: alloc_cnt <= alloc_cnt;
        endcase
      end
    end
  end

  // Entry storage: PC written at allocation, instruction and filled bit at response.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_pc[i]   <= '0;
        ent_inst[i] <= '0;
      end
      ent_filled <= '0;
    end else if (i_redirect) begin
      ent_filled <= '0;
    end else begin
      if (accept) begin
        ent_pc[alloc_ptr]     <= i_pc;
        ent_filled[alloc_ptr] <= 1'b0;
      end
      if (rsp_fill) begin
        ent_inst[fill_ptr]   <= i_imem_rsp_data;
        ent_filled[fill_ptr] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb/tb_instr_fetch_queue.sv - scoreboard bench for instr_fetch_queue
module tb_instr_fetch_queue;

  logic        i_clk;
  logic        i_rst_n;
  logic [35:0] i_pc;
  logic        o_pc_advance;
  logic        o_imem_req_valid;
  logic [35:0] o_imem_addr;
  logic        i_imem_req_ready;
  logic        i_imem_rsp_valid;
  logic [35:0] i_imem_rsp_data;
  logic        i_redirect;
  logic        o_inst_valid;
  logic [35:0] o_inst;
  logic [35:0] o_inst_pc;
  logic        i_inst_ready;
  logic        o_err_spurious;

  instr_fetch_queue dut (
    .i_clk            (i_clk),
    .i_rst_n          (i_rst_n),
    .i_pc             (i_pc),
    .o_pc_advance     (o_pc_advance),
    .o_imem_req_valid (o_imem_req_valid),
    .o_imem_addr      (o_imem_addr),
    .i_imem_req_ready (i_imem_req_ready),
    .i_imem_rsp_valid (i_imem_rsp_valid),
    .i_imem_rsp_data  (i_imem_rsp_data),
    .i_redirect       (i_redirect),
    .o_inst_valid     (o_inst_valid),
    .o_inst           (o_inst),
    .o_inst_pc        (o_inst_pc),
    .i_inst_ready     (i_inst_ready),
    .o_err_spurious   (o_err_spurious)
  );

  typedef struct { logic [35:0] pc; logic [35:0] inst; } exp_t;
  typedef struct { int due; logic [35:0] addr; } mem_t;

  exp_t exp_q[$];
  mem_t mem_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int lat = 1;
  int n_acc = 0, n_pop = 0, n_adv = 0;
  int first_acc = -1, first_valid = -1;
  int p0, a0, v0;
  logic [35:0] pc_model = '0;
  logic [35:0] redir_pc = '0;
  logic [35:0] last_pop_pc = '0;
  bit mem_rdy = 0, inst_rdy = 0, redir_req = 0, spur_req = 0;
  bit last_req_valid = 0, last_inst_valid = 0, last_pop = 0;

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive this cycle's inputs; memory answers in order after lat cycles.
  task automatic apply();
    mem_t m;
    i_pc             = pc_model;
    i_imem_req_ready = mem_rdy;
    i_inst_ready     = inst_rdy;
    i_redirect       = redir_req;
    redir_req        = 0;
    i_imem_rsp_valid = 1'b0;
    i_imem_rsp_data  = '0;
    if (spur_req) begin
      i_imem_rsp_valid = 1'b1;
      i_imem_rsp_data  = 36'hdead;
      spur_req         = 0;
    end else if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
      m = mem_q.pop_front();
      i_imem_rsp_valid = 1'b1;
      i_imem_rsp_data  = 36'h100 + m.addr;
    end
  endtask

  task automatic observe();
    logic acc, pop;
    exp_t e;
    acc = o_imem_req_valid & i_imem_req_ready;
    pop = o_inst_valid & i_inst_ready;
    last_req_valid  = o_imem_req_valid;
    last_inst_valid = o_inst_valid;
    last_pop        = pop;
    check("pc_advance", o_pc_advance, acc);
    if (o_pc_advance) n_adv++;
    if (o_inst_valid && first_valid < 0) first_valid = cyc;
    if (i_redirect) begin
      check("redir_no_issue", o_imem_req_valid, 0);
      check("redir_no_valid", o_inst_valid, 0);
    end
    if (pop) begin
      check("sb_pop_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("inst_pc", o_inst_pc, e.pc);
        check("inst", o_inst, e.inst);
      end
      last_pop_pc = o_inst_pc;
      n_pop++;
    end
    if (acc) begin
      check("imem_addr", o_imem_addr, pc_model);
      exp_q.push_back('{pc_model, 36'h100 + pc_model});
      mem_q.push_back('{cyc + lat, pc_model});
      n_acc++;
      if (first_acc < 0) first_acc = cyc;
    end
    if (i_redirect) begin
      pc_model = redir_pc;
      exp_q.delete();
    end else if (acc) begin
      pc_model = pc_model + 1;
    end
  endtask

  task automatic tick();
    apply();
    @(negedge i_clk);
    observe();
    @(posedge i_clk);
    #1;
    cyc++;
  endtask

  task automatic quiesce();
    bit done;
    done = 0;
    mem_rdy = 0;
    inst_rdy = 1;
    for (int i = 0; i < 60 && !done; i++) begin
      tick();
      done = (mem_q.size() == 0) && (exp_q.size() == 0);
    end
    check("quiesce_done", done, 1);
  endtask

  task automatic wait_pop(input string tag, input logic [35:0] exp_pc);
    bit got;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      tick();
      got = last_pop;
    end
    check({tag, "_seen"}, got, 1);
    if (got) check(tag, last_pop_pc, exp_pc);
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_pc = 36'h55;
    i_imem_req_ready = 1'b1;
    i_imem_rsp_valid = 1'b0;
    i_imem_rsp_data = '0;
    i_redirect = 1'b0;
    i_inst_ready = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    check("rst_req_valid", o_imem_req_valid, 0);
    check("rst_pc_advance", o_pc_advance, 0);
    check("rst_inst_valid", o_inst_valid, 0);
    check("rst_inst", o_inst, 0);
    check("rst_inst_pc", o_inst_pc, 0);
    check("rst_err", o_err_spurious, 0);
    check("rst_addr", o_imem_addr, 36'h55);
    pc_model = '0;
    i_pc = '0;
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;

    // 1: streaming with 1-cycle memory
    lat = 1; mem_rdy = 1; inst_rdy = 1;
    repeat (8) tick();
    check("t1_first_latency", first_valid - first_acc, 2);
    p0 = n_pop;
    repeat (10) tick();
    check("t1_throughput", n_pop - p0, 10);
    quiesce();

    // 2: decode stalled, queue fills, then drains
    lat = 1; mem_rdy = 1; inst_rdy = 0;
    a0 = n_acc; v0 = n_adv;
    repeat (10) tick();
    check("t2_accepts", n_acc - a0, 4);
    check("t2_adv_pulses", n_adv - v0, 4);
    check("t2_full_no_req", last_req_valid, 0);
    inst_rdy = 1;
    tick();
    check("t2_first_pop", last_pop, 1);
    check("t2_pop_no_issue", last_req_valid, 0);
    tick();
    check("t2_issue_resumes", last_req_valid, 1);
    quiesce();

    // 3: redirect with 3 requests in flight
    lat = 3; mem_rdy = 1; inst_rdy = 1;
    repeat (3) tick();
    redir_req = 1; redir_pc = 36'h40;
    tick();
    tick();
    check("t3_empty_r1", last_inst_valid, 0);
    check("t3_issue_r1", last_req_valid, 1);
    wait_pop("t3_first_pc", 36'h40);
    quiesce();

    // 4: response coincides with redirect, inflight 2
    lat = 2; mem_rdy = 1; inst_rdy = 1;
    repeat (2) tick();
    mem_rdy = 0; redir_req = 1; redir_pc = 36'h80;
    p0 = n_pop;
    tick();
    repeat (4) tick();
    check("t4_no_stale", n_pop - p0, 0);
    mem_rdy = 1;
    wait_pop("t4_first_pc", 36'h80);
    quiesce();

    // 5: spurious response with nothing in flight
    check("t5_err_before", o_err_spurious, 0);
    mem_rdy = 0; spur_req = 1;
    p0 = n_pop;
    tick();
    check("t5_err_set", o_err_spurious, 1);
    repeat (4) tick();
    check("t5_no_pop", n_pop - p0, 0);
    check("t5_no_valid", last_inst_valid, 0);
    lat = 1; mem_rdy = 1; inst_rdy = 1;
    repeat (8) tick();
    check("t5_err_sticky", o_err_spurious, 1);

    // 6: asynchronous reset mid-stream
    apply();
    #2;
    i_rst_n = 1'b0;
    #1;
    check("t6_req_valid", o_imem_req_valid, 0);
    check("t6_pc_advance", o_pc_advance, 0);
    check("t6_inst_valid", o_inst_valid, 0);
    check("t6_inst", o_inst, 0);
    check("t6_inst_pc", o_inst_pc, 0);
    check("t6_err", o_err_spurious, 0);
    exp_q.delete();
    mem_q.delete();
    i_imem_rsp_valid = 1'b0;
    pc_model = 36'h20;
    i_pc = 36'h20;
    @(posedge i_clk);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    check("t6_err_after", o_err_spurious, 0);
    wait_pop("t6_first_pc", 36'h20);
    quiesce();
    check("sb_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
- Fetch stage directly downstream of the program counter.
- Takes the current PC and issues in-order word-addressed requests to instruction memory.
- Buffers returned instructions with their PCs in a DEPTH-entry circular queue and hands them to decode over a valid/ready handshake.
- Controls PC advance; flushes on redirect, discarding in-flight responses.

Parameters:
- AW, 36, instruction address width (word address)
- IW, 36, instruction word width
- DEPTH, 4, queue entries; power of 2, ≥2
- MAX_INFLIGHT, 4, max outstanding memory requests; ≤DEPTH

Ports:
- i_clk  input  1  clock, rising edge
- i_rst_n  input  1  asynchronous active-low reset
- i_pc  input  AW  current PC value
- o_pc_advance  output  1  PC increments on the next edge when high
- o_imem_req_valid  output  1  memory request valid
- o_imem_addr  output  AW  request address
- i_imem_req_ready  input  1  memory accepts request
- i_imem_rsp_valid  input  1  response valid (in order, ≥1 cycle after accept)
- i_imem_rsp_data  input  IW  response instruction word
- i_redirect  input  1  flush pulse; PC is reloaded upstream in the same cycle
- o_inst_valid  output  1  head instruction valid to decode
- o_inst  output  IW  head instruction
- o_inst_pc  output  AW  PC of head instruction
- i_inst_ready  input  1  decode accepts head
- o_err_spurious  output  1  sticky: response received with nothing in flight

Behaviour:
- Reset, asynchronous on i_rst_n low: all pointers, counters and valid bits are 0, and o_err_spurious is 0. Every output is therefore 0, with o_imem_addr = i_pc.
- Queue state: alloc_ptr, fill_ptr and rd_ptr, each log2(DEPTH) bits, wrapping mod DEPTH. Each entry holds {pc, inst, filled}.
- Counters:
  - alloc_cnt (0..DEPTH) counts live allocated entries.
  - inflight (0..MAX_INFLIGHT) counts requests accepted but not yet answered.
  - drop_cnt counts in-flight responses still to be discarded.
- Issue: o_imem_req_valid = !i_redirect & alloc_cnt < DEPTH & inflight < MAX_INFLIGHT.
  - o_imem_addr = i_pc.
  - o_pc_advance = o_imem_req_valid & i_imem_req_ready.
- On accept:
  - Write pc into entry[alloc_ptr] and clear its filled bit.
  - alloc_ptr+1, alloc_cnt+1, inflight+1.
- Response when drop_cnt > 0: discard the data; drop_cnt−1, inflight−1.
- Response when drop_cnt == 0 and inflight > 0:
  - Write entry[fill_ptr].inst and set its filled bit.
  - fill_ptr+1, inflight−1.
- Response when inflight == 0 (and no accept in the same cycle): ignore it and set o_err_spurious. o_err_spurious clears only on reset.
- Output:
  - o_inst_valid = !i_redirect & alloc_cnt > 0 & entry[rd_ptr].filled.
  - o_inst and o_inst_pc are taken from entry[rd_ptr].
  - Pop on o_inst_valid & i_inst_ready: rd_ptr+1, alloc_cnt−1.
- Latency: request accepted at cycle T, response at T+L, then o_inst_valid at T+L+1 (registered fill, no bypass).
- Simultaneous events:
  - An accept and a pop in the same cycle leave alloc_cnt unchanged.
  - An accept and a response in the same cycle leave inflight unchanged.
  - A full queue with a pop this cycle does not issue this cycle; issue resumes next cycle.
- Redirect, cycle R:
  - No issue and no pop in R; o_inst_valid = 0.
  - Any response in R is discarded.
  - Next state:
    - alloc_cnt = 0.
    - All filled bits are cleared.
    - alloc_ptr = fill_ptr = rd_ptr.
    - inflight = inflight − rsp.
    - drop_cnt = that same new inflight value.
  - Issue may resume at R+1 using the reloaded i_pc.
  - A back-to-back redirect recomputes drop_cnt from the current inflight.
- Reset mid-operation: all state clears immediately. The memory system is reset by the same reset, so no stale responses are expected.

Test Plan:
1. Reset, then i_imem_req_ready=1 and 1-cycle memory latency returning data = 0x100 + addr, i_inst_ready=1, i_pc starting at 0 → decode sees PCs 0,1,2,3… with insts 0x100,0x101,…; steady state is one instruction per cycle; first o_inst_valid arrives 2 cycles after the first accept.
2. i_inst_ready=0, memory always ready → exactly 4 accepts, o_pc_advance pulses 4 times, o_imem_req_valid=0 while the queue is full; raising i_inst_ready drains 4 instructions in order and issue restarts the cycle after the first pop.
3. Latency 3, 3 requests in flight, i_redirect pulsed with the PC reloaded to 0x40 → 3 responses discarded, queue empty at R+1, next delivered instruction has o_inst_pc=0x40.
4. Response and i_redirect in the same cycle with inflight=2 → that response is discarded, drop_cnt=1, exactly one more response dropped, no stale instruction reaches decode.
5. i_imem_rsp_valid pulsed with inflight=0 → queue unchanged, o_err_spurious=1 and held until i_rst_n low.
6. i_rst_n low asynchronously mid-stream (between clock edges) → all outputs drop immediately; after release, fetch restarts from i_pc with empty queue and o_err_spurious=0.
